// File: rtl/shot_sequencer.sv
// Shot capture sequencer: clears, arms and stops the four mic counters,
// then flags the result to the host and holds off while the target rings.
module shot_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16000,
  parameter int unsigned QUIET_CYCLES   = 65535
) (
  input  logic       clk8M,
  input  logic       reset,
  input  logic       arm_req,
  input  logic       abort_req,
  input  logic       ack,
  input  logic       auto_rearm,
  input  logic [3:0] run,
  output logic       clear,
  output logic       stop,
  output logic       armed,
  output logic       shot_ready,
  output logic       timeout,
  output logic [3:0] missing,
  output logic [7:0] shot_count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_ARMED   = 3'd2,
    S_CAPTURE = 3'd3,
    S_STOP    = 3'd4,
    S_DONE    = 3'd5,
    S_QUIET   = 3'd6
  } state_e;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] Q_LAST   = 16'(QUIET_CYCLES - 1);

  state_e      state_q, state_d;
  logic        abort_stop_q, abort_stop_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic [15:0] q_cnt_q, q_cnt_d;
  logic        clear_q, clear_d;
  logic        stop_q, stop_d;
  logic        armed_q, armed_d;
  logic        shot_ready_q, shot_ready_d;
  logic        timeout_q, timeout_d;
  logic [3:0]  missing_q, missing_d;
  logic [7:0]  shot_count_q, shot_count_d;

  always_comb begin
    state_d      = state_q;
    abort_stop_d = abort_stop_q;
    tmo_cnt_d    = tmo_cnt_q;
    q_cnt_d      = q_cnt_q;
    timeout_d    = timeout_q;
    missing_d    = missing_q;
    shot_count_d = shot_count_q;

    if (abort_req && state_q != S_IDLE) begin
      // An abort during capture still stops the counters once.
      if (state_q == S_ARMED || state_q == S_CAPTURE) begin
        state_d      = S_STOP;
        abort_stop_d = 1'b1;
      end else begin
        state_d      = S_IDLE;
        abort_stop_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (arm_req) state_d = S_CLEAR;
        end
        S_CLEAR: begin
          timeout_d = 1'b0;
          missing_d = 4'h0;
          tmo_cnt_d = 16'd0;
          state_d   = S_ARMED;
        end
        S_ARMED: begin
          if (run == 4'hF) begin
            state_d = S_STOP;
          end else if (run != 4'h0) begin
            state_d   = S_CAPTURE;
            tmo_cnt_d = 16'd0;
          end
        end
        S_CAPTURE: begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
          if (run == 4'hF) begin
            state_d = S_STOP;
          end else if (tmo_cnt_q == TMO_LAST) begin
            state_d   = S_STOP;
            timeout_d = 1'b1;
          end
        end
        S_STOP: begin
          if (abort_stop_q) begin
            state_d      = S_IDLE;
            abort_stop_d = 1'b0;
          end else begin
            missing_d    = ~run;
            shot_count_d = shot_count_q + 8'd1;
            state_d      = S_DONE;
          end
        end
        S_DONE: begin
          if (ack) begin
            state_d = S_QUIET;
            q_cnt_d = 16'd0;
          end
        end
        S_QUIET: begin
          q_cnt_d = q_cnt_q + 16'd1;
          if (q_cnt_q == Q_LAST) begin
            state_d = auto_rearm ? S_CLEAR : S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    clear_d      = (state_d == S_CLEAR);
    stop_d       = (state_d == S_STOP);
    armed_d      = (state_d == S_ARMED) || (state_d == S_CAPTURE);
    shot_ready_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk8M) begin
    if (reset) begin
      state_q      <= S_IDLE;
      abort_stop_q <= 1'b0;
      tmo_cnt_q    <= 16'd0;
      q_cnt_q      <= 16'd0;
      clear_q      <= 1'b0;
      stop_q       <= 1'b0;
      armed_q      <= 1'b0;
      shot_ready_q <= 1'b0;
      timeout_q    <= 1'b0;
      missing_q    <= 4'h0;
      shot_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      abort_stop_q <= abort_stop_d;
      tmo_cnt_q    <= tmo_cnt_d;
      q_cnt_q      <= q_cnt_d;
      clear_q      <= clear_d;
      stop_q       <= stop_d;
      armed_q      <= armed_d;
      shot_ready_q <= shot_ready_d;
      timeout_q    <= timeout_d;
      missing_q    <= missing_d;
      shot_count_q <= shot_count_d;
    end
  end

  assign clear      = clear_q;
  assign stop       = stop_q;
  assign armed      = armed_q;
  assign shot_ready = shot_ready_q;
  assign timeout    = timeout_q;
  assign missing    = missing_q;
  assign shot_count = shot_count_q;
  assign state      = state_q;

endmodule

// File: tb/tb_shot_sequencer.sv
// Bench for shot_sequencer: directed and random shots checked against
// an arrival-time model of capture, timeout and quiet hold-off.
module tb_shot_sequencer;

  localparam int T = 100;
  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       reset, arm_req, abort_req, ack, auto_rearm;
  logic [3:0] run;
  logic       clear, stop, armed, shot_ready, timeout;
  logic [3:0] missing;
  logic [7:0] shot_count;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  shot_sequencer #(.TIMEOUT_CYCLES(T), .QUIET_CYCLES(Q)) dut (
    .clk8M(clk), .reset(reset), .arm_req(arm_req),
    .abort_req(abort_req), .ack(ack), .auto_rearm(auto_rearm),
    .run(run), .clear(clear), .stop(stop), .armed(armed),
    .shot_ready(shot_ready), .timeout(timeout), .missing(missing),
    .shot_count(shot_count), .state(state)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Mics that have fired by ARMED-relative cycle k (-1 = never fires).
  function automatic logic [3:0] mask(input int t[4], input int k);
    logic [3:0] m = 4'h0;
    for (int i = 0; i < 4; i++)
      if (t[i] >= 0 && t[i] <= k) m[i] = 1'b1;
    return m;
  endfunction

  task automatic arm();
    step();
    arm_req = 1'b1;
    step();
    arm_req = 1'b0;
    chk("arm_clear", 32'(clear), 32'd1);
    chk("arm_state", 32'(state), 32'd1);
    step();
    chk("armed", 32'(armed), 32'd1);
    chk("armed_clear_off", 32'(clear), 32'd0);
    chk("armed_tmo_clr", 32'(timeout), 32'd0);
  endtask

  // Entered on the first ARMED cycle (cycle 0).
  task automatic capture(input int t[4]);
    int first = 1 << 20;
    int mx = -1;
    bit allfire = 1'b1;
    int exp_stop, k;
    bit exp_to, saw_cap;
    logic [3:0] exp_miss;
    for (int i = 0; i < 4; i++) begin
      if (t[i] < 0) allfire = 1'b0;
      else begin
        if (t[i] < first) first = t[i];
        if (t[i] > mx) mx = t[i];
      end
    end
    if (allfire && mx <= first + T) begin
      exp_stop = mx + 1;
      exp_to   = 1'b0;
      exp_miss = 4'h0;
    end else begin
      exp_stop = first + T + 1;
      exp_to   = 1'b1;
      exp_miss = ~mask(t, exp_stop);
    end
    saw_cap = 1'b0;
    k = 0;
    run = mask(t, 0);
    while (k < 400) begin
      step();
      k++;
      if (state === 3'd3) saw_cap = 1'b1;
      if (stop === 1'b1) break;
      run = mask(t, k);
    end
    run = mask(t, k);
    chk("stop_cycle", 32'(k), 32'(exp_stop));
    chk("capture_seen", 32'(saw_cap),
        32'(!(allfire && mx == first)));
    step();
    exp_count = (exp_count + 1) % 256;
    chk("done_state", 32'(state), 32'd5);
    chk("shot_ready", 32'(shot_ready), 32'd1);
    chk("timeout", 32'(timeout), 32'(exp_to));
    chk("missing", 32'(missing), 32'(exp_miss));
    chk("shot_count", 32'(shot_count), 32'(exp_count));
  endtask

  task automatic finish_shot(input bit ar);
    int n;
    arm_req = 1'b1;
    step();
    arm_req = 1'b0;
    chk("arm_in_done", 32'(state), 32'd5);
    run = 4'h0;
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("ack_ready_off", 32'(shot_ready), 32'd0);
    chk("quiet_state", 32'(state), 32'd6);
    n = 0;
    while (n < 40) begin
      step();
      n++;
      if (ar && clear === 1'b1) break;
      if (!ar && state === 3'd0) break;
    end
    chk("quiet_len", 32'(n), 32'(Q));
    if (ar) begin
      step();
      chk("rearm_armed", 32'(armed), 32'd1);
    end
  endtask

  task automatic rand_times(output int t[4]);
    int first = int'($urandom_range(0, 20));
    for (int i = 0; i < 4; i++)
      t[i] = ($urandom_range(0, 3) == 0) ? -1
             : first + int'($urandom_range(0, 40));
    t[$urandom_range(0, 3)] = first;
  endtask

  initial begin
    int t[4];
    reset = 1'b1;
    arm_req = 1'b0;
    abort_req = 1'b0;
    ack = 1'b0;
    auto_rearm = 1'b0;
    run = 4'h0;
    repeat (3) step();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_outs", 32'({clear, stop, armed, shot_ready, timeout}), 32'd0);
    chk("rst_missing", 32'(missing), 32'd0);
    chk("rst_count", 32'(shot_count), 32'd0);
    reset = 1'b0;

    t = '{2, 9, 25, 40};
    arm(); capture(t); finish_shot(1'b0);
    t = '{0, 4, 8, -1};
    arm(); capture(t); finish_shot(1'b0);
    t = '{5, 5, 5, 5};
    arm(); capture(t); finish_shot(1'b0);
    t = '{1, 30, 60, 1 + T};
    arm(); capture(t); finish_shot(1'b0);
    t = '{1, 30, 60, 2 + T};
    arm(); capture(t); finish_shot(1'b0);

    arm();
    run = 4'h1;
    step();
    chk("abort_pre_state", 32'(state), 32'd3);
    abort_req = 1'b1;
    ack = 1'b1;
    step();
    abort_req = 1'b0;
    ack = 1'b0;
    chk("abort_stop", 32'(stop), 32'd1);
    chk("abort_stop_state", 32'(state), 32'd4);
    step();
    run = 4'h0;
    chk("abort_idle", 32'(state), 32'd0);
    chk("abort_ready", 32'(shot_ready), 32'd0);
    chk("abort_count", 32'(shot_count), 32'(exp_count));

    auto_rearm = 1'b1;
    arm();
    for (int s = 0; s < 256; s++) begin
      rand_times(t);
      capture(t);
      if (s == 255) auto_rearm = 1'b0;
      finish_shot(auto_rearm);
    end

    arm();
    run = 4'h4;
    step();
    chk("rst_pre_state", 32'(state), 32'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    run = 4'h0;
    exp_count = 0;
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_outs", 32'({clear, stop, armed, shot_ready, timeout}), 32'd0);
    chk("midrst_missing", 32'(missing), 32'd0);
    chk("midrst_count", 32'(shot_count), 32'(exp_count));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
